// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer.
// One-entry output slot per port, per-port accept counters.
module demux2_stream #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  a_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [N-1:0]  b_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] a_st;
  logic [0:0] b_st;
  logic       a_ok;
  logic       b_ok;
  logic       acc;
  logic       a_load;
  logic       b_load;

  assign a_valid = (a_st == FULL);
  assign b_valid = (b_st == FULL);

  // A slot can take a beat when empty or draining this cycle.
  assign a_ok = (a_st == EMPTY) | a_ready;
  assign b_ok = (b_st == EMPTY) | b_ready;

  // Ready depends only on the target slot, never on in_valid.
  assign in_ready = enable & (in_sel ? b_ok : a_ok);

  assign acc    = in_valid & in_ready;
  assign a_load = acc & ~in_sel;
  assign b_load = acc &  in_sel;

  // Port A slot state, data and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_st   <= EMPTY;
      a_data <= '0;
      cnt_a  <= '0;
    end else if (a_load) begin
      a_st   <= FULL;
      a_data <= in_data;
      cnt_a  <= cnt_a + CW'(1);
    end else if (a_ready) begin
      a_st   <= EMPTY;
    end
  end

  // Port B slot state, data and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_st   <= EMPTY;
      b_data <= '0;
      cnt_b  <= '0;
    end else if (b_load) begin
      b_st   <= FULL;
      b_data <= in_data;
      cnt_b  <= cnt_b + CW'(1);
    end else if (b_ready) begin
      b_st   <= EMPTY;
    end
  end

endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed stimulus, queue scoreboard
// and a negedge monitor on both output ports.
module tb_demux2_stream;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [N-1:0]  in_data = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a_data;
  logic          a_valid;
  logic          a_ready = 1'b1;
  logic [N-1:0]  b_data;
  logic          b_valid;
  logic          b_ready = 1'b1;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_a[$];
  logic [N-1:0] exp_b[$];
  logic [N-1:0] ea;
  logic [N-1:0] eb;

  demux2_stream #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid),
    .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid),
    .b_ready(b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: every completed output transfer pops a beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL a_pop: got %0h expected none",
                   a_data);
        end else begin
          ea = exp_a.pop_front();
          if (a_data !== ea) begin
            errors++;
            $display("FAIL a_pop: got %0h expected %0h",
                     a_data, ea);
          end
        end
      end
      if (b_valid && b_ready) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b_pop: got %0h expected none",
                   b_data);
        end else begin
          eb = exp_b.pop_front();
          if (b_data !== eb) begin
            errors++;
            $display("FAIL b_pop: got %0h expected %0h",
                     b_data, eb);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; returns the number of stalled cycles.
  task automatic send(input logic [N-1:0] d,
                      input logic s, output int lat);
    bit done;
    lat = 0;
    done = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (s) exp_b.push_back(d);
        else   exp_a.push_back(d);
        done = 1;
      end else begin
        lat++;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got stall expected accept");
    end
  endtask

  task automatic do_reset();
    a_ready = 1'b1;
    b_ready = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    chk("drain_a", exp_a.size(), 0);
    chk("drain_b", exp_b.size(), 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int lat;
  int tot;

  initial begin
    // Reset state
    step();
    step();
    @(negedge clk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst = 1'b0;

    // Routing
    send(8'h11, 1'b0, lat);
    chk("rt_lat_a", lat, 0);
    chk("rt_a_valid", a_valid, 1);
    chk("rt_a_data", a_data, 8'h11);
    send(8'h22, 1'b1, lat);
    chk("rt_lat_b", lat, 0);
    chk("rt_b_valid", b_valid, 1);
    chk("rt_b_data", b_data, 8'h22);
    chk("rt_cnt_a", cnt_a, 1);
    chk("rt_cnt_b", cnt_b, 1);

    // Backpressure and hold
    do_reset();
    a_ready = 1'b0;
    send(8'h5A, 1'b0, lat);
    in_data  = 8'h5B;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_a_data", a_data, 8'h5A);
      step();
    end
    a_ready = 1'b1;
    send(8'h5B, 1'b0, lat);
    chk("bp_lat", lat, 0);
    chk("bp_a_data2", a_data, 8'h5B);
    chk("bp_cnt_a", cnt_a, 2);

    // No head-of-line blocking
    a_ready = 1'b0;
    in_sel = 1'b1;
    @(negedge clk);
    chk("hol_in_ready", in_ready, 1);
    step();
    send(8'h77, 1'b1, lat);
    chk("hol_lat", lat, 0);
    chk("hol_b_data", b_data, 8'h77);
    chk("hol_a_data", a_data, 8'h5B);
    chk("hol_a_valid", a_valid, 1);
    a_ready = 1'b1;

    // Full-rate alternating stream
    do_reset();
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send(N'(i), i[0], lat);
      tot += lat;
    end
    chk("st_stalls", tot, 0);
    chk("st_cnt_a", cnt_a, 8);
    chk("st_cnt_b", cnt_b, 8);

    // Enable gating
    step();
    a_ready = 1'b0;
    send(8'h33, 1'b0, lat);
    enable   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h44;
    in_sel   = 1'b0;
    @(negedge clk);
    chk("en_rdy_a", in_ready, 0);
    step();
    in_sel = 1'b1;
    @(negedge clk);
    chk("en_rdy_b", in_ready, 0);
    step();
    step();
    chk("en_cnt_a", cnt_a, 9);
    chk("en_cnt_b", cnt_b, 8);
    chk("en_a_full", a_valid, 1);
    a_ready = 1'b1;
    step();
    chk("en_a_drain", a_valid, 0);
    chk("en_cnt_a2", cnt_a, 9);
    in_valid = 1'b0;
    enable   = 1'b1;

    // Counter wrap at CW bits
    do_reset();
    for (int i = 0; i < 17; i++)
      send(N'(8'h80 + i), 1'b1, lat);
    chk("wr_cnt_b", cnt_b, 1);
    chk("wr_cnt_a", cnt_a, 0);

    // Mid-operation reset
    step();
    a_ready = 1'b0;
    send(8'h99, 1'b0, lat);
    chk("mr_a_valid_pre", a_valid, 1);
    rst = 1'b1;
    step();
    chk("mr_a_valid", a_valid, 0);
    chk("mr_cnt_a", cnt_a, 0);
    chk("mr_cnt_b", cnt_b, 0);
    chk("mr_a_data", a_data, 0);
    exp_a.delete();
    rst = 1'b0;
    a_ready = 1'b1;
    step();
    step();
    chk("end_q_a", exp_a.size(), 0);
    chk("end_q_b", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
